// File: rtl/fft_sdf_bf2_stage.sv
// fft_sdf_bf2_stage: radix-2 single-path delay-feedback butterfly stage.
// Sum/difference against a DELAY-deep feedback line, difference rotated by the twiddle.
module fft_sdf_bf2_stage #(
   parameter int DATA_W = 24,
   parameter int FRAC_W = 8,
   parameter int DELAY  = 2,
   parameter int FRAME  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] din_r_i,
   input  logic [DATA_W-1:0] din_i_i,
   input  logic [DATA_W-1:0] w_r_i,
   input  logic [DATA_W-1:0] w_i_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] dout_r_o,
   output logic [DATA_W-1:0] dout_i_o,
   output logic [1:0]        phase_o
);
   localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_BFLY = 2'd2, S_FLUSH = 2'd3;
   localparam int SW = DELAY > 1 ? $clog2(DELAY) : 1;
   localparam int FW = FRAME > 1 ? $clog2(FRAME) : 1;
   localparam int PW = 2 * DATA_W + 1;
   localparam logic [SW-1:0] SEG_LAST = SW'(DELAY - 1);
   localparam logic [FW-1:0] CNT_LAST = FW'(FRAME - 1);

   logic [1:0]        ph_q, ph_d;
   logic [SW-1:0]     seg_q, seg_d, sc;
   logic [FW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] lr_q [DELAY];
   logic [DATA_W-1:0] li_q [DELAY];
   logic              lt_q [DELAY];
   logic              ov_q, ov_d;
   logic [DATA_W-1:0] or_q, oi_q, or_d, oi_d;
   logic [DATA_W-1:0] dr, di, rr, ri, pr_d, pi_d;
   logic signed [PW-1:0] er, ei, wr, wi, prod_r, prod_i;
   logic              fill, bfly, fl, step, last;

   // lt_q tags entries holding rotated differences; only those are emitted outside BFLY,
   // which lets a new frame start mid-flush while the old differences drain out in order
   always_comb begin
      fill   = in_valid_i & (ph_q != S_BFLY);
      bfly   = in_valid_i & (ph_q == S_BFLY);
      fl     = ~in_valid_i & (ph_q == S_FLUSH);
      step   = fill | bfly | fl;
      sc     = fill ? ((ph_q == S_FILL) ? seg_q : '0) : seg_q;
      last   = sc == SEG_LAST;
      dr     = lr_q[0] - din_r_i;
      di     = li_q[0] - din_i_i;
      er     = PW'($signed(dr));
      ei     = PW'($signed(di));
      wr     = PW'($signed(w_r_i));
      wi     = PW'($signed(w_i_i));
      prod_r = er * wr - ei * wi;
      prod_i = er * wi + ei * wr;
      rr     = DATA_W'(prod_r >>> FRAC_W);
      ri     = DATA_W'(prod_i >>> FRAC_W);
      ov_d   = bfly | fl | (fill & lt_q[0]);
      or_d   = ov_d ? (bfly ? lr_q[0] + din_r_i : lr_q[0]) : or_q;
      oi_d   = ov_d ? (bfly ? li_q[0] + din_i_i : li_q[0]) : oi_q;
      pr_d   = bfly ? rr : fill ? din_r_i : '0;
      pi_d   = bfly ? ri : fill ? din_i_i : '0;
      seg_d  = step ? (last ? '0 : sc + SW'(1)) : seg_q;
      cnt_d  = (fill | bfly) ? (cnt_q == CNT_LAST ? '0 : cnt_q + FW'(1)) : cnt_q;
      ph_d   = !step ? ph_q :
               fill  ? (last ? S_BFLY : S_FILL) :
               bfly  ? (last ? (cnt_q == CNT_LAST ? S_FLUSH : S_FILL) : S_BFLY) :
                       (last ? S_IDLE : S_FLUSH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q  <= S_IDLE;
         seg_q <= '0;
         cnt_q <= '0;
         ov_q  <= 1'b0;
         or_q  <= '0;
         oi_q  <= '0;
         for (int i = 0; i < DELAY; i++) begin
            lr_q[i] <= '0;
            li_q[i] <= '0;
            lt_q[i] <= 1'b0;
         end
      end else begin
         ph_q  <= ph_d;
         seg_q <= seg_d;
         cnt_q <= cnt_d;
         ov_q  <= ov_d;
         or_q  <= or_d;
         oi_q  <= oi_d;
         if (step) begin
            for (int i = 0; i < DELAY - 1; i++) begin
               lr_q[i] <= lr_q[i+1];
               li_q[i] <= li_q[i+1];
               lt_q[i] <= lt_q[i+1];
            end
            lr_q[DELAY-1] <= pr_d;
            li_q[DELAY-1] <= pi_d;
            lt_q[DELAY-1] <= bfly;
         end
      end
   end

   assign out_valid_o = ov_q;
   assign dout_r_o    = or_q;
   assign dout_i_o    = oi_q;
   assign phase_o     = ph_q;
endmodule

// File: tb/tb_fft_sdf_bf2_stage.sv
// tb_fft_sdf_bf2_stage: directed vector tables for the cycle-exact cases, then random frames
// checked against a pair-wise butterfly model of the output stream.
module tb_fft_sdf_bf2_stage;
   localparam int DW = 24;
   localparam int D  = 2;
   localparam int F  = 4;

   typedef struct {
      bit v;
      int xr, xi, wr, wi;
      bit ev;
      int er, ei, ep;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
   logic          out_valid;
   logic [DW-1:0] dout_r, dout_i;
   logic [1:0]    phase;
   int            checks = 0, errors = 0;

   logic [DW-1:0] eq_r [$], eq_i [$];
   logic [DW-1:0] a_r [D], a_i [D], p_r [D], p_i [D];
   int            nidx = 0;
   vec_t          ta [$], tbl [$];

   always #5 clk = ~clk;

   fft_sdf_bf2_stage #(.DATA_W(DW), .FRAC_W(8), .DELAY(D), .FRAME(F)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid),
      .din_r_i(din_r), .din_i_i(din_i), .w_r_i(w_r), .w_i_i(w_i),
      .out_valid_o(out_valid), .dout_r_o(dout_r), .dout_i_o(dout_i), .phase_o(phase)
   );

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, ".valid"}, DW'(out_valid), '0);
      chk({name, ".dout_r"}, dout_r, '0);
      chk({name, ".dout_i"}, dout_i, '0);
      chk({name, ".phase"}, DW'(phase), '0);
   endtask

   task automatic apply(input vec_t t, input string name);
      @(negedge clk);
      in_valid = t.v;
      din_r = DW'(t.xr);
      din_i = DW'(t.xi);
      w_r = DW'(t.wr);
      w_i = DW'(t.wi);
      @(posedge clk);
      #1;
      chk({name, ".valid"}, DW'(out_valid), DW'(t.ev));
      chk({name, ".dout_r"}, dout_r, DW'(t.er));
      chk({name, ".dout_i"}, dout_i, DW'(t.ei));
      chk({name, ".phase"}, DW'(phase), DW'(t.ep));
   endtask

   function automatic void rot(input logic [DW-1:0] dr, di, wr, wi, output logic [DW-1:0] rr, ri);
      longint a = longint'($signed(dr));
      longint b = longint'($signed(di));
      longint c = longint'($signed(wr));
      longint d = longint'($signed(wi));
      rr = DW'((a * c - b * d) >>> 8);
      ri = DW'((a * d + b * c) >>> 8);
   endfunction

   // first half of each pair is remembered; second half yields sums now and rotated diffs after the pair
   task automatic model(input logic [DW-1:0] xr, xi, wr, wi);
      int j = nidx % D;
      if ((nidx / D) % 2 == 0) begin
         a_r[j] = xr;
         a_i[j] = xi;
      end else begin
         eq_r.push_back(a_r[j] + xr);
         eq_i.push_back(a_i[j] + xi);
         rot(a_r[j] - xr, a_i[j] - xi, wr, wi, p_r[j], p_i[j]);
         if (j == D - 1)
            for (int k = 0; k < D; k++) begin
               eq_r.push_back(p_r[k]);
               eq_i.push_back(p_i[k]);
            end
      end
      nidx = (nidx + 1) % F;
   endtask

   task automatic rcyc(input logic v);
      logic [DW-1:0] er, ei;
      @(negedge clk);
      if (out_valid) begin
         if (eq_r.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stream: unexpected output 0x%0h 0x%0h", dout_r, dout_i);
         end else begin
            er = eq_r.pop_front();
            ei = eq_i.pop_front();
            chk("stream.r", dout_r, er);
            chk("stream.i", dout_i, ei);
         end
      end
      in_valid = v;
      din_r = DW'($urandom);
      din_i = DW'($urandom);
      w_r = DW'($urandom);
      w_i = DW'($urandom);
      if (v) model(din_r, din_i, w_r, w_i);
   endtask

   initial begin
      ta = '{
         '{1, 256, 0, 999, 999, 0, 0, 0, 1},
         '{1, 512, 0, 0, 0, 0, 0, 0, 2},
         '{1, 768, 0, 256, 0, 1, 1024, 0, 2},
         '{1, 1024, 0, 0, -256, 1, 1536, 0, 3},
         '{0, 77, 77, 0, 0, 1, -512, 0, 3},
         '{0, 0, 0, 0, 0, 1, 0, 512, 0},
         '{0, 0, 0, 0, 0, 0, 0, 512, 0}
      };
      tbl = '{
         '{1, 256, 0, 5, 5, 0, 0, 512, 1},
         '{0, 9, 9, 0, 0, 0, 0, 512, 1},
         '{0, 9, 9, 0, 0, 0, 0, 512, 1},
         '{0, 9, 9, 0, 0, 0, 0, 512, 1},
         '{1, 512, 0, 0, 0, 0, 0, 512, 2},
         '{1, 768, 0, 256, 0, 1, 1024, 0, 2},
         '{1, 1024, 0, 0, -256, 1, 1536, 0, 3},
         '{0, 0, 0, 0, 0, 1, -512, 0, 3},
         '{0, 0, 0, 0, 0, 1, 0, 512, 0},
         '{1, 256, 0, 0, 0, 0, 0, 512, 1},
         '{1, 512, 0, 0, 0, 0, 0, 512, 2},
         '{1, 768, 0, 256, 0, 1, 1024, 0, 2},
         '{1, 1024, 0, 0, -256, 1, 1536, 0, 3},
         '{1, 100, 10, 0, 0, 1, -512, 0, 1},
         '{1, 200, 20, 0, 0, 1, 0, 512, 2},
         '{1, 300, 30, 0, 256, 1, 400, 40, 2},
         '{1, 400, 40, 256, 0, 1, 600, 60, 3},
         '{0, 0, 0, 0, 0, 1, 20, -200, 3},
         '{0, 0, 0, 0, 0, 1, -200, -20, 0},
         '{0, 0, 0, 0, 0, 0, -200, -20, 0},
         '{1, 0, 0, 0, 0, 0, -200, -20, 1},
         '{1, 0, 0, 0, 0, 0, -200, -20, 2},
         '{1, 1, 0, 128, 0, 1, 1, 0, 2},
         '{1, 0, 0, 256, 0, 1, 0, 0, 3},
         '{0, 0, 0, 0, 0, 1, -1, 0, 3},
         '{0, 0, 0, 0, 0, 1, 0, 0, 0}
      };
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = i[0];
         din_r = DW'($urandom);
         din_i = DW'($urandom);
         @(posedge clk);
         #1;
         chk_zero($sformatf("reset[%0d]", i));
      end
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      foreach (ta[i]) apply(ta[i], $sformatf("frame[%0d]", i));
      foreach (tbl[i]) apply(tbl[i], $sformatf("seq[%0d]", i));
      for (int i = 0; i < 3; i++) apply(ta[i], $sformatf("pre_rst[%0d]", i));
      @(negedge clk);
      in_valid = 1'b1;
      din_r = DW'(1024);
      din_i = '0;
      w_r = '0;
      w_i = DW'(-256);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(posedge clk);
      #1;
      chk_zero("mid_rst_edge");
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b0;
      foreach (ta[i]) apply(ta[i], $sformatf("post_rst[%0d]", i));
      for (int f = 0; f < 25; f++) begin
         for (int n = 0; n < F; n++) begin
            while ($urandom_range(0, 2) == 0) rcyc(1'b0);
            rcyc(1'b1);
         end
         repeat ($urandom_range(0, 3)) rcyc(1'b0);
      end
      repeat (10) rcyc(1'b0);
      chk("drain", DW'(eq_r.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
